countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter ALARM_SEC, default 10, SHALL set the number of tick_1hz pulses the alarm stays asserted in DONE.
REQ-002 Parameter ZERO_PAT, default 32'h00A00A00, SHALL be the Data_in value meaning all digits zero.
REQ-003 Clk  input  1  sole clock, all logic on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 tick_1hz  input  1  one-Clk-cycle pulse once per second.
REQ-006 key_start, key_mode, key_sel, key_up, key_down, key_clr  input  1 each  debounced one-cycle key pulses.
REQ-007 Data_in  input  32  counter display word {s0,s1,A,m0,m1,A,h0,h1}.
REQ-008 cnt_inc  output  3  one-hot increment pulse: bit0 seconds, bit1 minutes, bit2 hours.
REQ-009 cnt_dec  output  3  one-hot decrement pulse, same field mapping.
REQ-010 cnt_down  output  1  one-cycle countdown-step pulse.
REQ-011 start_flag  output  1  one-cycle pulse: counter snapshots preset.
REQ-012 reset_flag  output  1  one-cycle pulse: counter reloads snapshot.
REQ-013 state  output  3  current state code.
REQ-014 sel_field  output  3  one-hot field under edit (display blink).
REQ-015 alarm  output  1  alarm drive, high only in DONE.

Function
REQ-016 States SHALL be IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4; other codes SHALL go to IDLE next cycle.
REQ-017 Key priority per cycle SHALL be key_clr > key_start > key_mode > key_sel > key_up > key_down; lower keys in that cycle are ignored.
REQ-018 All pulse outputs SHALL be registered, asserted exactly one cycle, in the cycle after the causing input; at most one of cnt_inc/cnt_dec/cnt_down/start_flag/reset_flag SHALL be nonzero per cycle.
REQ-019 IDLE: key_mode -> SET with sel_field=3'b001; key_start -> RUN with start_flag pulse.
REQ-020 SET: key_sel SHALL rotate sel_field 001->010->100->001; key_up pulses the cnt_inc bit equal to sel_field; key_down pulses the cnt_dec bit equal to sel_field; key_mode -> IDLE; key_start -> RUN with start_flag pulse.
REQ-021 sel_field SHALL be 3'b000 outside SET.
REQ-022 RUN: tick_1hz with Data_in != ZERO_PAT SHALL pulse cnt_down; Data_in == ZERO_PAT SHALL move to DONE immediately, regardless of tick, with no cnt_down.
REQ-023 RUN: key_start -> PAUSE; no cnt_down in PAUSE; key_start in PAUSE -> RUN without start_flag.
REQ-024 start_flag in IDLE/SET with Data_in == ZERO_PAT SHALL NOT be issued; state stays.
REQ-025 DONE: alarm=1; an internal counter SHALL count tick_1hz from 0; on reaching ALARM_SEC, or on any key pulse, alarm drops and state -> IDLE with reset_flag pulse.
REQ-026 key_clr in RUN, PAUSE or DONE SHALL pulse reset_flag and go to IDLE; key_clr in IDLE/SET SHALL go to IDLE with no pulse.
REQ-027 key_up/key_down outside SET SHALL have no effect.
REQ-028 Alarm counter SHALL be cleared on every entry to DONE, width ceil(log2(ALARM_SEC+1)).

Reset
REQ-029 Reset high SHALL asynchronously force state=IDLE, sel_field=0, alarm=0, all pulse outputs=0, alarm counter=0.
REQ-030 Reset asserted mid-RUN or mid-DONE SHALL abort without issuing reset_flag or start_flag.
REQ-031 First key or tick after Reset release SHALL be honoured on the following edge.

Structure
REQ-032 Shared package SHALL hold state codes, field one-hot constants, ZERO_PAT.
REQ-033 One sub-module, countdown_alarm_cnt (tick counter with clear and done flag), SHALL implement REQ-025/028; the FSM stays in countdown_ctrl.

Verification
REQ-034 Reset, key_mode, key_sel x2, key_up -> sel_field=100, cnt_inc=3'b100 pulse for one cycle.
REQ-035 Data_in=32'h10A00A00 in IDLE, key_start -> start_flag one cycle, state=RUN; tick -> cnt_down; then Data_in=ZERO_PAT -> state=DONE, alarm=1.
REQ-036 DONE, 10 ticks, ALARM_SEC=10 -> alarm=0, reset_flag pulse, state=IDLE.
REQ-037 RUN, key_start and key_clr same cycle -> reset_flag pulse, state=IDLE, no PAUSE.
REQ-038 PAUSE, 3 ticks -> no cnt_down; key_start -> RUN, no start_flag.
REQ-039 Reset asserted mid-DONE -> alarm=0, state=IDLE asynchronously, no reset_flag.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// Countdown controller shared types.
// State codes, field masks, zero pattern.
package countdown_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] FLD_NONE = 3'b000;
  localparam logic [2:0] FLD_SEC  = 3'b001;
  localparam logic [2:0] FLD_MIN  = 3'b010;
  localparam logic [2:0] FLD_HR   = 3'b100;

  localparam logic [31:0] ZERO_PAT_DEF = 32'h00A00A00;

  // sec -> min -> hr -> sec
  function automatic logic [2:0] next_field(
    input logic [2:0] f
  );
    logic [2:0] r;
    case (f)
      FLD_SEC: r = FLD_MIN;
      FLD_MIN: r = FLD_HR;
      default: r = FLD_SEC;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Countdown controller key/display bus.
// master = key/tick source, slave = controller.
interface countdown_ctrl_if;
  logic        tick_1hz;
  logic        key_start;
  logic        key_mode;
  logic        key_sel;
  logic        key_up;
  logic        key_down;
  logic        key_clr;
  logic [31:0] Data_in;
  logic [2:0]  cnt_inc;
  logic [2:0]  cnt_dec;
  logic        cnt_down;
  logic        start_flag;
  logic        reset_flag;
  logic [2:0]  state;
  logic [2:0]  sel_field;
  logic        alarm;

  modport master (
    output tick_1hz, key_start, key_mode,
    output key_sel, key_up, key_down,
    output key_clr, Data_in,
    input  cnt_inc, cnt_dec, cnt_down,
    input  start_flag, reset_flag,
    input  state, sel_field, alarm
  );

  modport slave (
    input  tick_1hz, key_start, key_mode,
    input  key_sel, key_up, key_down,
    input  key_clr, Data_in,
    output cnt_inc, cnt_dec, cnt_down,
    output start_flag, reset_flag,
    output state, sel_field, alarm
  );
endinterface

// File: rtl/countdown_alarm_cnt.sv
// Alarm duration counter for DONE.
// Held clear while disabled; done on last tick.
module countdown_alarm_cnt #(
  parameter int ALARM_SEC = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int W =
    (ALARM_SEC < 1) ? 1 : $clog2(ALARM_SEC + 1);
  localparam logic [W-1:0] LAST = W'(ALARM_SEC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // done fires on the tick that would reach ALARM_SEC
  assign done_o = en_i & tick_i & (cnt_q == LAST);

  // clear outside DONE so every entry starts at 0
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)
      cnt_d = '0;
    else if (tick_i && !done_o)
      cnt_d = cnt_q + W'(1);
  end

  // counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer control FSM.
// Keys/ticks in, registered pulses out.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int          ALARM_SEC = 10,
  parameter logic [31:0] ZERO_PAT  = ZERO_PAT_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  countdown_ctrl_if.slave  bus
);

  state_e     state_q;
  logic [2:0] sel_q;
  logic [2:0] inc_q;
  logic [2:0] dec_q;
  logic       down_q;
  logic       sf_q;
  logic       rf_q;
  logic       alarm_q;

  logic zero;
  logic any_key;
  logic alarm_done;

  assign zero    = (bus.Data_in == ZERO_PAT);
  assign any_key = bus.key_clr  | bus.key_start |
                   bus.key_mode | bus.key_sel   |
                   bus.key_up   | bus.key_down;

  countdown_alarm_cnt #(
    .ALARM_SEC (ALARM_SEC)
  ) u_alarm (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .en_i   (state_q == ST_DONE),
    .tick_i (bus.tick_1hz),
    .done_o (alarm_done)
  );

  // state machine with registered pulse outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sel_q   <= FLD_NONE;
      inc_q   <= '0;
      dec_q   <= '0;
      down_q  <= 1'b0;
      sf_q    <= 1'b0;
      rf_q    <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      inc_q  <= '0;
      dec_q  <= '0;
      down_q <= 1'b0;
      sf_q   <= 1'b0;
      rf_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.key_clr) begin
            state_q <= ST_IDLE;
          end else if (bus.key_start) begin
            if (!zero) begin
              state_q <= ST_RUN;
              sf_q    <= 1'b1;
            end
          end else if (bus.key_mode) begin
            state_q <= ST_SET;
            sel_q   <= FLD_SEC;
          end
        end
        ST_SET: begin
          if (bus.key_clr) begin
            state_q <= ST_IDLE;
            sel_q   <= FLD_NONE;
          end else if (bus.key_start) begin
            if (!zero) begin
              state_q <= ST_RUN;
              sel_q   <= FLD_NONE;
              sf_q    <= 1'b1;
            end
          end else if (bus.key_mode) begin
            state_q <= ST_IDLE;
            sel_q   <= FLD_NONE;
          end else if (bus.key_sel) begin
            sel_q <= next_field(sel_q);
          end else if (bus.key_up) begin
            inc_q <= sel_q;
          end else if (bus.key_down) begin
            dec_q <= sel_q;
          end
        end
        ST_RUN: begin
          if (bus.key_clr) begin
            state_q <= ST_IDLE;
            rf_q    <= 1'b1;
          end else if (bus.key_start) begin
            state_q <= ST_PAUSE;
          end else if (zero) begin
            state_q <= ST_DONE;
            alarm_q <= 1'b1;
          end else if (bus.tick_1hz) begin
            down_q <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.key_clr) begin
            state_q <= ST_IDLE;
            rf_q    <= 1'b1;
          end else if (bus.key_start) begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (any_key || alarm_done) begin
            state_q <= ST_IDLE;
            rf_q    <= 1'b1;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= FLD_NONE;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_inc    = inc_q;
  assign bus.cnt_dec    = dec_q;
  assign bus.cnt_down   = down_q;
  assign bus.start_flag = sf_q;
  assign bus.reset_flag = rf_q;
  assign bus.state      = state_q;
  assign bus.sel_field  = sel_q;
  assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl.
// Table-driven steps through an expectation queue.
module tb_countdown_ctrl;

  localparam logic [31:0] ZP = 32'h00A00A00;
  localparam logic [31:0] NZ = 32'h10A00A00;

  localparam logic [5:0] K_NONE  = 6'b000000;
  localparam logic [5:0] K_DOWN  = 6'b000001;
  localparam logic [5:0] K_UP    = 6'b000010;
  localparam logic [5:0] K_SEL   = 6'b000100;
  localparam logic [5:0] K_MODE  = 6'b001000;
  localparam logic [5:0] K_START = 6'b010000;
  localparam logic [5:0] K_CLR   = 6'b100000;

  localparam logic [2:0] I = 3'd0;
  localparam logic [2:0] S = 3'd1;
  localparam logic [2:0] R = 3'd2;
  localparam logic [2:0] P = 3'd3;
  localparam logic [2:0] D = 3'd4;

  typedef struct {
    logic [5:0]  k;
    logic        t;
    logic        z;
    logic [15:0] e;
  } stim_t;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_q[$];

  countdown_ctrl_if bus();

  countdown_ctrl #(
    .ALARM_SEC (10),
    .ZERO_PAT  (ZP)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] ex(
    input logic [2:0] inc, input logic [2:0] dec,
    input logic dn, input logic sf, input logic rf,
    input logic [2:0] st, input logic [2:0] sel,
    input logic al
  );
    return {inc, dec, dn, sf, rf, st, sel, al};
  endfunction

  function automatic stim_t mk(
    input logic [5:0] k, input logic t,
    input logic z, input logic [15:0] e
  );
    stim_t s;
    s.k = k; s.t = t; s.z = z; s.e = e;
    return s;
  endfunction

  function automatic logic [15:0] obs();
    return {bus.cnt_inc, bus.cnt_dec, bus.cnt_down,
            bus.start_flag, bus.reset_flag, bus.state,
            bus.sel_field, bus.alarm};
  endfunction

  task automatic cyc(input logic [5:0] k, input logic t);
    {bus.key_clr, bus.key_start, bus.key_mode,
     bus.key_sel, bus.key_up, bus.key_down} = k;
    bus.tick_1hz = t;
    @(posedge Clk);
    #1;
    {bus.key_clr, bus.key_start, bus.key_mode,
     bus.key_sel, bus.key_up, bus.key_down} = '0;
    bus.tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    logic [15:0] g;
    Reset = 1'b1;
    bus.Data_in = NZ;
    {bus.key_clr, bus.key_start, bus.key_mode,
     bus.key_sel, bus.key_up, bus.key_down} = '0;
    bus.tick_1hz = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, I, 0, 0));
    repeat (2) @(posedge Clk);
    #1;
    g = obs();
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== e) begin
      $display("FAIL reset_state: got %h required %h", g, e);
      n_err++;
    end
    @(negedge Clk);
    Reset = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, I, 0, 0));
    cyc(K_NONE, 1'b1);
    g = obs();
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== e) begin
      $display("FAIL reset_idle: got %h required %h", g, e);
      n_err++;
    end
  endtask

  task automatic test_set_edit();
    stim_t tb[$];
    logic [15:0] g;
    logic [15:0] e;
    tb.push_back(mk(K_MODE, 0, 0, ex(0, 0, 0, 0, 0, S, 3'b001, 0)));
    tb.push_back(mk(K_SEL,  0, 0, ex(0, 0, 0, 0, 0, S, 3'b010, 0)));
    tb.push_back(mk(K_SEL,  0, 0, ex(0, 0, 0, 0, 0, S, 3'b100, 0)));
    tb.push_back(mk(K_UP,   0, 0, ex(3'b100, 0, 0, 0, 0, S, 3'b100, 0)));
    tb.push_back(mk(K_NONE, 0, 0, ex(0, 0, 0, 0, 0, S, 3'b100, 0)));
    tb.push_back(mk(K_DOWN, 0, 0, ex(0, 3'b100, 0, 0, 0, S, 3'b100, 0)));
    tb.push_back(mk(K_UP | K_DOWN, 0, 0,
                    ex(3'b100, 0, 0, 0, 0, S, 3'b100, 0)));
    tb.push_back(mk(K_SEL,  0, 0, ex(0, 0, 0, 0, 0, S, 3'b001, 0)));
    tb.push_back(mk(K_DOWN, 0, 0, ex(0, 3'b001, 0, 0, 0, S, 3'b001, 0)));
    tb.push_back(mk(K_SEL | K_UP, 1, 0,
                    ex(0, 0, 0, 0, 0, S, 3'b010, 0)));
    tb.push_back(mk(K_UP,   0, 0, ex(3'b010, 0, 0, 0, 0, S, 3'b010, 0)));
    tb.push_back(mk(K_MODE | K_SEL, 0, 0, ex(0, 0, 0, 0, 0, I, 0, 0)));
    tb.push_back(mk(K_UP,   0, 0, ex(0, 0, 0, 0, 0, I, 0, 0)));
    tb.push_back(mk(K_DOWN, 0, 0, ex(0, 0, 0, 0, 0, I, 0, 0)));
    foreach (tb[i]) begin
      bus.Data_in = tb[i].z ? ZP : NZ;
      exp_q.push_back(tb[i].e);
      cyc(tb[i].k, tb[i].t);
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL set_edit step %0d: got %h required %h",
                 i, g, e);
        n_err++;
      end
    end
  endtask

  task automatic test_run_done();
    stim_t tb[$];
    logic [15:0] g;
    logic [15:0] e;
    tb.push_back(mk(K_START, 0, 0, ex(0, 0, 0, 1, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  0, 0, ex(0, 0, 0, 0, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  1, 0, ex(0, 0, 1, 0, 0, R, 0, 0)));
    tb.push_back(mk(K_UP,    0, 0, ex(0, 0, 0, 0, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  1, 0, ex(0, 0, 1, 0, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  1, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    tb.push_back(mk(K_NONE,  0, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    foreach (tb[i]) begin
      bus.Data_in = tb[i].z ? ZP : NZ;
      exp_q.push_back(tb[i].e);
      cyc(tb[i].k, tb[i].t);
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL run_done step %0d: got %h required %h",
                 i, g, e);
        n_err++;
      end
    end
  endtask

  task automatic test_alarm_timeout();
    stim_t tb[$];
    logic [15:0] g;
    logic [15:0] e;
    for (int n = 0; n < 9; n++) begin
      tb.push_back(mk(K_NONE, 1, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
      tb.push_back(mk(K_NONE, 0, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    end
    tb.push_back(mk(K_NONE,  1, 1, ex(0, 0, 0, 0, 1, I, 0, 0)));
    tb.push_back(mk(K_NONE,  0, 1, ex(0, 0, 0, 0, 0, I, 0, 0)));
    tb.push_back(mk(K_START, 0, 1, ex(0, 0, 0, 0, 0, I, 0, 0)));
    tb.push_back(mk(K_MODE,  0, 1, ex(0, 0, 0, 0, 0, S, 3'b001, 0)));
    tb.push_back(mk(K_START | K_UP, 0, 1,
                    ex(0, 0, 0, 0, 0, S, 3'b001, 0)));
    tb.push_back(mk(K_CLR,   0, 1, ex(0, 0, 0, 0, 0, I, 0, 0)));
    foreach (tb[i]) begin
      bus.Data_in = tb[i].z ? ZP : NZ;
      exp_q.push_back(tb[i].e);
      cyc(tb[i].k, tb[i].t);
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL alarm_timeout step %0d: got %h required %h",
                 i, g, e);
        n_err++;
      end
    end
  endtask

  task automatic test_clr_priority();
    stim_t tb[$];
    logic [15:0] g;
    logic [15:0] e;
    tb.push_back(mk(K_START, 0, 0, ex(0, 0, 0, 1, 0, R, 0, 0)));
    tb.push_back(mk(K_START | K_CLR, 1, 0,
                    ex(0, 0, 0, 0, 1, I, 0, 0)));
    tb.push_back(mk(K_NONE,  0, 0, ex(0, 0, 0, 0, 0, I, 0, 0)));
    tb.push_back(mk(K_CLR,   0, 0, ex(0, 0, 0, 0, 0, I, 0, 0)));
    tb.push_back(mk(K_MODE,  0, 0, ex(0, 0, 0, 0, 0, S, 3'b001, 0)));
    tb.push_back(mk(K_CLR | K_START, 0, 0,
                    ex(0, 0, 0, 0, 0, I, 0, 0)));
    foreach (tb[i]) begin
      bus.Data_in = tb[i].z ? ZP : NZ;
      exp_q.push_back(tb[i].e);
      cyc(tb[i].k, tb[i].t);
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL clr_priority step %0d: got %h required %h",
                 i, g, e);
        n_err++;
      end
    end
  endtask

  task automatic test_pause();
    stim_t tb[$];
    logic [15:0] g;
    logic [15:0] e;
    tb.push_back(mk(K_START, 0, 0, ex(0, 0, 0, 1, 0, R, 0, 0)));
    tb.push_back(mk(K_START, 1, 0, ex(0, 0, 0, 0, 0, P, 0, 0)));
    for (int n = 0; n < 3; n++)
      tb.push_back(mk(K_NONE, 1, 0, ex(0, 0, 0, 0, 0, P, 0, 0)));
    tb.push_back(mk(K_START, 0, 0, ex(0, 0, 0, 0, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  1, 0, ex(0, 0, 1, 0, 0, R, 0, 0)));
    tb.push_back(mk(K_CLR,   0, 0, ex(0, 0, 0, 0, 1, I, 0, 0)));
    foreach (tb[i]) begin
      bus.Data_in = tb[i].z ? ZP : NZ;
      exp_q.push_back(tb[i].e);
      cyc(tb[i].k, tb[i].t);
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL pause step %0d: got %h required %h",
                 i, g, e);
        n_err++;
      end
    end
  endtask

  task automatic test_done_reentry();
    stim_t tb[$];
    logic [15:0] g;
    logic [15:0] e;
    tb.push_back(mk(K_START, 0, 0, ex(0, 0, 0, 1, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  0, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    for (int n = 0; n < 5; n++)
      tb.push_back(mk(K_NONE, 1, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    tb.push_back(mk(K_SEL,   0, 1, ex(0, 0, 0, 0, 1, I, 0, 0)));
    tb.push_back(mk(K_START, 0, 0, ex(0, 0, 0, 1, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  1, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    for (int n = 0; n < 9; n++)
      tb.push_back(mk(K_NONE, 1, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    tb.push_back(mk(K_NONE,  1, 1, ex(0, 0, 0, 0, 1, I, 0, 0)));
    foreach (tb[i]) begin
      bus.Data_in = tb[i].z ? ZP : NZ;
      exp_q.push_back(tb[i].e);
      cyc(tb[i].k, tb[i].t);
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL done_reentry step %0d: got %h required %h",
                 i, g, e);
        n_err++;
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t tb[$];
    logic [15:0] g;
    logic [15:0] e;
    tb.push_back(mk(K_START, 0, 0, ex(0, 0, 0, 1, 0, R, 0, 0)));
    tb.push_back(mk(K_NONE,  0, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    tb.push_back(mk(K_NONE,  1, 1, ex(0, 0, 0, 0, 0, D, 0, 1)));
    foreach (tb[i]) begin
      bus.Data_in = tb[i].z ? ZP : NZ;
      exp_q.push_back(tb[i].e);
      cyc(tb[i].k, tb[i].t);
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL async_reset step %0d: got %h required %h",
                 i, g, e);
        n_err++;
      end
    end
    for (int ph = 0; ph < 2; ph++) begin
      #2;
      Reset = 1'b1;
      exp_q.push_back(ex(0, 0, 0, 0, 0, I, 0, 0));
      #1;
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL async_reset_now ph%0d: got %h required %h",
                 ph, g, e);
        n_err++;
      end
      exp_q.push_back(ex(0, 0, 0, 0, 0, I, 0, 0));
      @(posedge Clk);
      #1;
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL async_reset_hold ph%0d: got %h required %h",
                 ph, g, e);
        n_err++;
      end
      @(negedge Clk);
      Reset = 1'b0;
      bus.Data_in = NZ;
      if (ph == 0) begin
        exp_q.push_back(ex(0, 0, 0, 1, 0, R, 0, 0));
        cyc(K_START, 1'b0);
      end else begin
        exp_q.push_back(ex(0, 0, 0, 0, 0, S, 3'b001, 0));
        cyc(K_MODE, 1'b0);
      end
      g = obs();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        $display("FAIL first_key ph%0d: got %h required %h",
                 ph, g, e);
        n_err++;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_set_edit();
    bus.Data_in = NZ;
    cyc(K_CLR, 1'b0);
    test_run_done();
    test_alarm_timeout();
    test_clr_priority();
    test_pause();
    test_done_reentry();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d left required 0",
               exp_q.size());
      n_err++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
